exec_system_ctrl: RTL and testbench
===================================

// Module: exec_system_ctrl
// PURPOSE
//  Execute-stage unit for SYSTEM-opcode instructions; parametrised successor to the single-cycle system unit.
//  Adds MRET+SRET (optional S-mode), mstatus.TW/TSR checks, a WFI wait FSM with in_ready backpressure and abort.
//  Sits beside ALU/LSU in exec; drives the CSR file request port; feeds writeback/trap logic.
// PARAMETERS
//  XLEN          64     data width of rs1_data, csr_result, out_result, mstatus
//  ALEN          64     address width of mepc, sepc
//  HAS_SMODE     1      1: SRET and S-mode WFI/TSR rules are legal paths; 0: SRET is illegal
//  WFI_TIMEOUT   1024   WFI self-release cycle count; used only with EXEC_SYSTEM_WFI_TIMEOUT_EN; range 1..2^20
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous active-high reset
//  in_valid       in   1     SYSTEM instruction presented this cycle
//  in_ready       out  1     0 while FSM is in WAIT; in_valid is ignored when 0
//  flush          in   1     mispredict/trap kill; aborts WAIT; suppresses out_valid for this cycle's input
//  funct7,rs2,rs1,funct3,rd  in  7,5,5,3,5   instruction fields
//  i_imm          in   12    CSR address
//  rs1_data       in   XLEN  rs1 value
//  privilege_mode in   2     U=0, S=1, M=3
//  mstatus        in   XLEN  bit 21 TW, bit 22 TSR
//  mepc, sepc     in   ALEN  xRET targets (aligned)
//  interrupt      in   1     pending enabled interrupt (wakes WFI)
//  csr_valid      out  1     comb: in_valid & in_ready & !flush & funct3 not in {000,100}
//  csr_addr/funct3/rd/rs1_uimm/rs1_data  out  12/3/5/5/XLEN  comb pass-through of instruction fields
//  csr_exception, csr_cause, csr_result  in  1/4/XLEN  CSR file response, same cycle as csr_valid
//  will_do_xret   out  1     comb: legal, accepted MRET/SRET; commits mstatus updates
//  out_valid      out  1     registered completion pulse
//  out_exception, out_cause, out_is_xret, out_xret_level, out_result  out  1/4/1/2/XLEN  registered result
// BEHAVIOUR
//  Reset: FSM=IDLE; out_valid=0, out_exception=0, out_is_xret=0, out_cause=0, out_xret_level=0, out_result=0; in_ready=1.
//  Accept: in_valid & in_ready & !flush. Non-WFI instructions: outputs registered 1 cycle later, out_valid high exactly 1 cycle.
//  Decode priority (first match):
//   funct3==100                  -> illegal (cause 2)
//   funct3!=000                  -> out_exception/out_cause/out_result = csr_exception/csr_cause/csr_result
//   rd!=0                        -> illegal
//   funct7==0001001 (SFENCE.VMA) -> no-op, no exception, any rs1/rs2
//   rs1!=0                       -> illegal
//   {funct7,rs2}==0 ECALL        -> cause 8/9/11 for U/S/M; priv==2 gives illegal
//   {funct7,rs2}==1 EBREAK       -> cause 3
//   MRET (0011000,00010)         -> is_xret=1, level=3, result=mepc zero-extended; exception iff priv!=M
//   SRET (0001000,00010)         -> is_xret=1, level=1, result=sepc; exception iff !HAS_SMODE | priv==U | (priv==S & TSR)
//   WFI  (0001000,00101)         -> illegal iff priv==U | (priv==S & TW); else enter WAIT
//   other                        -> illegal
//  Illegal-instruction responses always have out_cause=2; out_result=0 on every exception.
//  will_do_xret: high only for an accepted MRET/SRET that completes with no exception.
//  FSM: IDLE --legal WFI accepted--> WAIT (no out_valid at entry).
//   WAIT: in_ready=0; interrupt=1 -> out_valid next cycle with no exception, result 0; back to IDLE.
//   WAIT & flush (incl. same cycle as interrupt): -> IDLE, no out_valid; flush wins.
//   interrupt already high when WFI accepted: WAIT lasts 1 cycle; out_valid 2 cycles after accept.
//  flush in IDLE: input not accepted and no out_valid next cycle; a completion pulse already registered
//   on this cycle is still presented unchanged.
//  rst mid-WAIT: IDLE next cycle; no out_valid.
// CONFIGURATION
//  EXEC_SYSTEM_WFI_TIMEOUT_EN defined: counter cleared on WAIT entry, increments each cycle in WAIT.
//   When it reaches WFI_TIMEOUT-1 with no interrupt: normal completion (no exception) next cycle, then IDLE.
//   Interrupt and timeout in the same cycle: treated as interrupt; identical response.
//  Not defined: no counter is synthesised; WAIT exits only on interrupt, flush or rst.
// TESTING
//  ECALL with priv=S -> out_valid 1 cycle later, out_exception=1, out_cause=9, out_is_xret=0.
//  MRET with priv=M, mepc=0x8000_1000 -> will_do_xret=1 same cycle; next cycle is_xret=1, level=3,
//   result=0x8000_1000, no exception. MRET with priv=S -> exception, cause 2, will_do_xret=0.
//  SRET with priv=S, mstatus[22]=1 -> cause 2. HAS_SMODE=0: SRET with priv=M -> cause 2.
//  WFI with priv=M, interrupt raised 5 cycles after accept -> in_ready=0 for 5 cycles; out_valid 1 cycle after the
//   interrupt, no exception. Same WFI with flush at cycle 3 -> no out_valid, in_ready=1 next cycle.
//  Macro defined, WFI_TIMEOUT=8, no interrupt -> completion at cycle 9 after accept. Macro undefined -> WAIT persists 100 cycles.
//  CSRRW with csr_exception=1, csr_cause=2 -> csr_valid=1, forwarded next cycle; in_valid asserted while in WAIT -> csr_valid=0.

Source files
------------

// File: rtl/exec_system_ctrl.sv
// Execute-stage SYSTEM-opcode unit: CSR request routing, ECALL/EBREAK/xRET/WFI decode, WFI wait FSM.
// Latency: 1 cycle for every non-WFI instruction; WFI completes 1 cycle after the wake condition.
// Backpressure: in_ready drops for the whole WAIT state; in_valid is ignored while in_ready is low.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       instruction handshake; flush kills this cycle's input and aborts WAIT
//   funct7, rs2, rs1, funct3, rd, i_imm, rs1_data   decoded instruction fields and rs1 value
//   privilege_mode            U=0, S=1, M=3
//   mstatus                   bit 21 = TW, bit 22 = TSR
//   mepc, sepc                xRET targets
//   interrupt                 pending enabled interrupt, wakes WFI
//   csr_*                     CSR file request (combinational) and same-cycle response
//   will_do_xret              combinational: accepted MRET/SRET that will complete without exception
//   out_*                     registered completion; out_valid is a single-cycle pulse
//
// Optional feature: define EXEC_SYSTEM_WFI_TIMEOUT_EN to add a WFI self-release counter that
// completes WAIT after WFI_TIMEOUT cycles without an interrupt. Undefined: no counter exists.

module exec_system_ctrl #(
  parameter int XLEN        = 64,
  parameter int ALEN        = 64,
  parameter int HAS_SMODE   = 1,
  parameter int WFI_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rs1,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  input  logic [11:0]     i_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [1:0]      privilege_mode,
  input  logic [XLEN-1:0] mstatus,
  input  logic [ALEN-1:0] mepc,
  input  logic [ALEN-1:0] sepc,
  input  logic            interrupt,
  output logic            csr_valid,
  output logic [11:0]     csr_addr,
  output logic [2:0]      csr_funct3,
  output logic [4:0]      csr_rd,
  output logic [4:0]      csr_rs1_uimm,
  output logic [XLEN-1:0] csr_rs1_data,
  input  logic            csr_exception,
  input  logic [3:0]      csr_cause,
  input  logic [XLEN-1:0] csr_result,
  output logic            will_do_xret,
  output logic            out_valid,
  output logic            out_exception,
  output logic [3:0]      out_cause,
  output logic            out_is_xret,
  output logic [1:0]      out_xret_level,
  output logic [XLEN-1:0] out_result
);

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_BREAK    = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U  = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_S  = 4'd9;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;

  // {funct7, rs2} encodings of the rs1==0/rd==0 privileged group
  localparam logic [11:0] ENC_ECALL  = 12'h000;
  localparam logic [11:0] ENC_EBREAK = 12'h001;
  localparam logic [11:0] ENC_SRET   = {7'b0001000, 5'b00010};
  localparam logic [11:0] ENC_MRET   = {7'b0011000, 5'b00010};
  localparam logic [11:0] ENC_WFI    = {7'b0001000, 5'b00101};
  localparam logic [6:0]  F7_SFENCE  = 7'b0001001;

  typedef struct packed {
    logic            exc;
    logic [3:0]      cause;
    logic            is_xret;
    logic [1:0]      level;
    logic [XLEN-1:0] result;
  } resp_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state;
  resp_t  dec;
  resp_t  out_q;
  logic   dec_wfi;
  logic   accept;
  logic   wake;
  logic   mstatus_tw;
  logic   mstatus_tsr;
  logic   unused_mstatus;

  assign mstatus_tw     = mstatus[21];
  assign mstatus_tsr    = mstatus[22];
  assign unused_mstatus = ^{mstatus[XLEN-1:23], mstatus[20:0]};

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready & ~flush;

  // CSR request: everything with funct3 other than 000 (privileged group) and 100 (reserved)
  assign csr_valid    = accept & (funct3 != 3'b000) & (funct3 != 3'b100);
  assign csr_addr     = i_imm;
  assign csr_funct3   = funct3;
  assign csr_rd       = rd;
  assign csr_rs1_uimm = rs1;
  assign csr_rs1_data = rs1_data;

  // Instruction decode; first matching rule wins
  always_comb begin
    dec     = '0;
    dec_wfi = 1'b0;
    if (funct3 == 3'b100) begin
      dec.exc   = 1'b1;
      dec.cause = CAUSE_ILLEGAL;
    end else if (funct3 != 3'b000) begin
      dec.exc    = csr_exception;
      dec.cause  = csr_cause;
      dec.result = csr_result;
    end else if (rd != 5'd0) begin
      dec.exc   = 1'b1;
      dec.cause = CAUSE_ILLEGAL;
    end else if (funct7 == F7_SFENCE) begin
      // SFENCE.VMA: no TLB here, retires as a no-op
      dec.exc = 1'b0;
    end else if (rs1 != 5'd0) begin
      dec.exc   = 1'b1;
      dec.cause = CAUSE_ILLEGAL;
    end else begin
      case ({funct7, rs2})
        ENC_ECALL: begin
          dec.exc = 1'b1;
          case (privilege_mode)
            PRIV_U:  dec.cause = CAUSE_ECALL_U;
            PRIV_S:  dec.cause = CAUSE_ECALL_S;
            PRIV_M:  dec.cause = CAUSE_ECALL_M;
            default: dec.cause = CAUSE_ILLEGAL;
          endcase
        end
        ENC_EBREAK: begin
          dec.exc   = 1'b1;
          dec.cause = CAUSE_BREAK;
        end
        ENC_MRET: begin
          dec.is_xret = 1'b1;
          dec.level   = 2'd3;
          dec.result  = XLEN'(mepc);
          if (privilege_mode != PRIV_M) begin
            dec.exc   = 1'b1;
            dec.cause = CAUSE_ILLEGAL;
          end
        end
        ENC_SRET: begin
          dec.is_xret = 1'b1;
          dec.level   = 2'd1;
          dec.result  = XLEN'(sepc);
          if ((HAS_SMODE == 0) || (privilege_mode == PRIV_U) ||
              ((privilege_mode == PRIV_S) && mstatus_tsr)) begin
            dec.exc   = 1'b1;
            dec.cause = CAUSE_ILLEGAL;
          end
        end
        ENC_WFI: begin
          if ((privilege_mode == PRIV_U) || ((privilege_mode == PRIV_S) && mstatus_tw)) begin
            dec.exc   = 1'b1;
            dec.cause = CAUSE_ILLEGAL;
          end else begin
            dec_wfi = 1'b1;
          end
        end
        default: begin
          dec.exc   = 1'b1;
          dec.cause = CAUSE_ILLEGAL;
        end
      endcase
    end
    // Exceptions never leak a result value to writeback
    if (dec.exc) begin
      dec.result = '0;
    end
  end

  assign will_do_xret = accept & dec.is_xret & ~dec.exc;

`ifdef EXEC_SYSTEM_WFI_TIMEOUT_EN
  localparam int CNT_W = (WFI_TIMEOUT > 1) ? $clog2(WFI_TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  assign timeout_hit = (wait_cnt == CNT_W'(WFI_TIMEOUT - 1));
  // A timeout coinciding with an interrupt produces the same completion, so they simply OR
  assign wake        = interrupt | timeout_hit;
`else
  assign wake = interrupt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_q     <= '0;
`ifdef EXEC_SYSTEM_WFI_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec_wfi) begin
              // Entering WAIT produces no completion; the pulse comes on wake
              state <= S_WAIT;
`ifdef EXEC_SYSTEM_WFI_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              out_valid <= 1'b1;
              out_q     <= dec;
            end
          end
        end
        S_WAIT: begin
          if (flush) begin
            // Kill has priority over a same-cycle wake
            state <= S_IDLE;
          end else if (wake) begin
            state     <= S_IDLE;
            out_valid <= 1'b1;
            out_q     <= '0;
          end else begin
`ifdef EXEC_SYSTEM_WFI_TIMEOUT_EN
            wait_cnt <= wait_cnt + CNT_W'(1);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_exception  = out_q.exc;
  assign out_cause      = out_q.cause;
  assign out_is_xret    = out_q.is_xret;
  assign out_xret_level = out_q.level;
  assign out_result     = out_q.result;

endmodule

// File: tb/tb_exec_system_ctrl.sv
module tb_exec_system_ctrl;
  localparam int XLEN = 64;
  localparam int ALEN = 64;

  localparam logic [11:0] ECALL  = 12'h000;
  localparam logic [11:0] EBREAK = 12'h001;
  localparam logic [11:0] MRET   = 12'h302;
  localparam logic [11:0] SRET   = 12'h102;
  localparam logic [11:0] WFI    = 12'h105;
  localparam logic [11:0] SFENCE = 12'h123;
  localparam logic [11:0] BOGUS  = 12'h0ff;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, flush, interrupt;
  logic [6:0]      funct7;
  logic [4:0]      rs2, rs1, rd;
  logic [2:0]      funct3;
  logic [11:0]     i_imm;
  logic [XLEN-1:0] rs1_data, mstatus, csr_result;
  logic [1:0]      privilege_mode;
  logic [ALEN-1:0] mepc, sepc;
  logic            csr_exception;
  logic [3:0]      csr_cause;

  logic            in_ready, csr_valid, will_do_xret, out_valid, out_exception, out_is_xret;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_funct3;
  logic [4:0]      csr_rd, csr_rs1_uimm;
  logic [XLEN-1:0] csr_rs1_data, out_result;
  logic [3:0]      out_cause;
  logic [1:0]      out_xret_level;

  logic            n_in_ready, n_csr_valid, n_will_do_xret, n_out_valid, n_out_exception, n_out_is_xret;
  logic [11:0]     n_csr_addr;
  logic [2:0]      n_csr_funct3;
  logic [4:0]      n_csr_rd, n_csr_rs1_uimm;
  logic [XLEN-1:0] n_csr_rs1_data, n_out_result;
  logic [3:0]      n_out_cause;
  logic [1:0]      n_out_xret_level;

  always #5 clk = ~clk;

  exec_system_ctrl #(.XLEN(XLEN), .ALEN(ALEN), .HAS_SMODE(1), .WFI_TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .funct7(funct7), .rs2(rs2), .rs1(rs1), .funct3(funct3), .rd(rd), .i_imm(i_imm),
    .rs1_data(rs1_data), .privilege_mode(privilege_mode), .mstatus(mstatus),
    .mepc(mepc), .sepc(sepc), .interrupt(interrupt),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_rd(csr_rd),
    .csr_rs1_uimm(csr_rs1_uimm), .csr_rs1_data(csr_rs1_data),
    .csr_exception(csr_exception), .csr_cause(csr_cause), .csr_result(csr_result),
    .will_do_xret(will_do_xret), .out_valid(out_valid), .out_exception(out_exception),
    .out_cause(out_cause), .out_is_xret(out_is_xret), .out_xret_level(out_xret_level),
    .out_result(out_result)
  );

  exec_system_ctrl #(.XLEN(XLEN), .ALEN(ALEN), .HAS_SMODE(0), .WFI_TIMEOUT(8)) u_dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .flush(flush),
    .funct7(funct7), .rs2(rs2), .rs1(rs1), .funct3(funct3), .rd(rd), .i_imm(i_imm),
    .rs1_data(rs1_data), .privilege_mode(privilege_mode), .mstatus(mstatus),
    .mepc(mepc), .sepc(sepc), .interrupt(interrupt),
    .csr_valid(n_csr_valid), .csr_addr(n_csr_addr), .csr_funct3(n_csr_funct3), .csr_rd(n_csr_rd),
    .csr_rs1_uimm(n_csr_rs1_uimm), .csr_rs1_data(n_csr_rs1_data),
    .csr_exception(csr_exception), .csr_cause(csr_cause), .csr_result(csr_result),
    .will_do_xret(n_will_do_xret), .out_valid(n_out_valid), .out_exception(n_out_exception),
    .out_cause(n_out_cause), .out_is_xret(n_out_is_xret), .out_xret_level(n_out_xret_level),
    .out_result(n_out_result)
  );

  typedef struct {
    logic        exc;
    logic [3:0]  cause;
    logic        chk_x;
    logic        is_xret;
    logic [1:0]  lvl;
    logic [63:0] res;
  } exp_t;

  exp_t exp_q[$];
  exp_t ns_q[$];
  exp_t mon_e, mon_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic exc, input logic [3:0] c, input logic cx,
                              input logic x, input logic [1:0] l, input logic [63:0] r);
    exp_t e;
    e.exc = exc; e.cause = c; e.chk_x = cx; e.is_xret = x; e.lvl = l; e.res = r;
    return e;
  endfunction

  task automatic push2(input exp_t a, input exp_t b);
    exp_q.push_back(a);
    ns_q.push_back(b);
  endtask

  // Scoreboard monitors: one per instance, pop on every completion pulse
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_exception", out_exception, mon_e.exc);
        chk("out_cause", out_cause, mon_e.cause);
        if (mon_e.chk_x) begin
          chk("out_is_xret", out_is_xret, mon_e.is_xret);
          chk("out_xret_level", out_xret_level, mon_e.lvl);
        end
        chk("out_result", out_result, mon_e.res);
      end
    end
    if (!rst && n_out_valid) begin
      if (ns_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ns_unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        mon_n = ns_q.pop_front();
        chk("ns_out_exception", n_out_exception, mon_n.exc);
        chk("ns_out_cause", n_out_cause, mon_n.cause);
        if (mon_n.chk_x) begin
          chk("ns_out_is_xret", n_out_is_xret, mon_n.is_xret);
          chk("ns_out_xret_level", n_out_xret_level, mon_n.lvl);
        end
        chk("ns_out_result", n_out_result, mon_n.res);
      end
    end
  end

  // Called at posedge+1; presents one instruction for one cycle and returns at the next posedge+1
  task automatic send(input logic [11:0] f7rs2, input logic [2:0] f3, input logic [1:0] pv,
                      input logic exp_wdx, input logic exp_cv);
    in_valid       = 1'b1;
    funct7         = f7rs2[11:5];
    rs2            = f7rs2[4:0];
    funct3         = f3;
    privilege_mode = pv;
    #1;
    chk("will_do_xret", will_do_xret, exp_wdx);
    chk("csr_valid", csr_valid, exp_cv);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    funct7 = '0; rs2 = '0; rs1 = '0; rd = '0; funct3 = '0; i_imm = '0; rs1_data = '0;
    mstatus = '0; csr_exception = 1'b0; csr_cause = '0; csr_result = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  exp_t ok0;
  exp_t ill;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; interrupt = 1'b0;
    funct7 = '0; rs2 = '0; rs1 = '0; funct3 = '0; rd = '0; i_imm = '0; rs1_data = '0;
    privilege_mode = 2'd3; mstatus = '0; mepc = 64'h8000_1000; sepc = 64'h4000_0200;
    csr_exception = 1'b0; csr_cause = '0; csr_result = '0;
    ok0 = mk(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 64'd0);
    ill = mk(1'b1, 4'd2, 1'b1, 1'b0, 2'd0, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_exception", out_exception, 0);
    chk("rst_out_cause", out_cause, 0);
    chk("rst_out_is_xret", out_is_xret, 0);
    chk("rst_out_xret_level", out_xret_level, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // ECALL per privilege
    push2(mk(1'b1, 4'd9, 1'b1, 1'b0, 2'd0, 0), mk(1'b1, 4'd9, 1'b1, 1'b0, 2'd0, 0));
    send(ECALL, 3'b000, 2'd1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("out_valid_one_cycle", out_valid, 0);
    push2(mk(1'b1, 4'd8, 1'b1, 1'b0, 2'd0, 0), mk(1'b1, 4'd8, 1'b1, 1'b0, 2'd0, 0));
    send(ECALL, 3'b000, 2'd0, 1'b0, 1'b0);
    push2(mk(1'b1, 4'd11, 1'b1, 1'b0, 2'd0, 0), mk(1'b1, 4'd11, 1'b1, 1'b0, 2'd0, 0));
    send(ECALL, 3'b000, 2'd3, 1'b0, 1'b0);
    push2(ill, ill);
    send(ECALL, 3'b000, 2'd2, 1'b0, 1'b0);
    push2(mk(1'b1, 4'd3, 1'b1, 1'b0, 2'd0, 0), mk(1'b1, 4'd3, 1'b1, 1'b0, 2'd0, 0));
    send(EBREAK, 3'b000, 2'd3, 1'b0, 1'b0);

    // MRET legal / illegal
    push2(mk(1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 64'h8000_1000), mk(1'b0, 4'd0, 1'b1, 1'b1, 2'd3, 64'h8000_1000));
    send(MRET, 3'b000, 2'd3, 1'b1, 1'b0);
    push2(mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0), mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0));
    send(MRET, 3'b000, 2'd1, 1'b0, 1'b0);

    // SRET: TSR trap, legal in S, legal in M; HAS_SMODE=0 instance always traps
    mstatus = 64'h40_0000;
    push2(mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0), mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0));
    send(SRET, 3'b000, 2'd1, 1'b0, 1'b0);
    push2(mk(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 64'h4000_0200), mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0));
    send(SRET, 3'b000, 2'd1, 1'b1, 1'b0);
    push2(mk(1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 64'h4000_0200), mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0));
    send(SRET, 3'b000, 2'd3, 1'b1, 1'b0);
    push2(mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0), mk(1'b1, 4'd2, 1'b0, 1'b0, 2'd0, 0));
    send(SRET, 3'b000, 2'd0, 1'b0, 1'b0);

    // SFENCE.VMA with nonzero rs1/rs2, then decode-order illegals
    rs1 = 5'd5;
    push2(ok0, ok0);
    send(SFENCE, 3'b000, 2'd1, 1'b0, 1'b0);
    rd = 5'd1;
    push2(ill, ill);
    send(ECALL, 3'b000, 2'd3, 1'b0, 1'b0);
    rs1 = 5'd2;
    push2(ill, ill);
    send(EBREAK, 3'b000, 2'd3, 1'b0, 1'b0);
    push2(ill, ill);
    send(BOGUS, 3'b000, 2'd3, 1'b0, 1'b0);
    push2(ill, ill);
    send(ECALL, 3'b100, 2'd3, 1'b0, 1'b0);

    // CSR path: exception forwarded, then a normal result plus field pass-through
    csr_exception = 1'b1; csr_cause = 4'd2;
    push2(ill, ill);
    send(ECALL, 3'b001, 2'd3, 1'b0, 1'b1);
    csr_result = 64'h1234_5678_9abc_def0; i_imm = 12'h300; rs1 = 5'd7; rs1_data = 64'hdead_beef;
    #1;
    chk("csr_addr", csr_addr, 12'h300);
    chk("csr_rs1_uimm", csr_rs1_uimm, 5'd7);
    chk("csr_rs1_data", csr_rs1_data, 64'hdead_beef);
    push2(mk(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 64'h1234_5678_9abc_def0),
          mk(1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 64'h1234_5678_9abc_def0));
    send(ECALL, 3'b010, 2'd3, 1'b0, 1'b1);

    // Flush in IDLE: the pulse from the previous accept is still presented, new input dropped
    flush = 1'b1;
    send(ECALL, 3'b001, 2'd3, 1'b0, 1'b0);
    chk("flush_idle_no_out", out_valid, 0);

    // WFI traps from U and from S with TW
    push2(ill, ill);
    send(WFI, 3'b000, 2'd0, 1'b0, 1'b0);
    mstatus = 64'h20_0000;
    push2(ill, ill);
    send(WFI, 3'b000, 2'd1, 1'b0, 1'b0);

    // WFI in M, interrupt 5 cycles after accept
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("wfi_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("wfi_in_ready_low", in_ready, 0);
    interrupt = 1'b1;
    push2(ok0, ok0);
    @(posedge clk); #1;
    interrupt = 1'b0;
    chk("wfi_wake_out_valid", out_valid, 1);
    chk("wfi_wake_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // WFI aborted by flush at cycle 3, interrupt in the same cycle; CSR attempt during WAIT
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; funct3 = 3'b001;
    #1;
    chk("csr_valid_in_wait", csr_valid, 0);
    in_valid = 1'b0; funct3 = 3'b000;
    @(posedge clk); #1;
    flush = 1'b1; interrupt = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; interrupt = 1'b0;
    chk("flush_wait_in_ready", in_ready, 1);
    chk("flush_wait_no_out", out_valid, 0);
    @(posedge clk); #1;
    chk("flush_wait_no_out_late", out_valid, 0);

    // Interrupt already pending at accept: completion 2 cycles after accept
    interrupt = 1'b1;
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    chk("wfi_pend_in_ready", in_ready, 0);
    chk("wfi_pend_no_early_out", out_valid, 0);
    push2(ok0, ok0);
    @(posedge clk); #1;
    interrupt = 1'b0;
    chk("wfi_pend_out_valid", out_valid, 1);
    chk("wfi_pend_in_ready_back", in_ready, 1);
    @(posedge clk); #1;

    // Reset in the middle of WAIT
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wait_in_ready", in_ready, 1);
    chk("rst_wait_no_out", out_valid, 0);
    @(posedge clk); #1;
    chk("rst_wait_no_out_late", out_valid, 0);

`ifdef EXEC_SYSTEM_WFI_TIMEOUT_EN
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      chk("wfi_timeout_in_ready_low", in_ready, 0);
      if (i == 8) push2(ok0, ok0);
      @(posedge clk); #1;
    end
    chk("wfi_timeout_out_valid", out_valid, 1);
    chk("wfi_timeout_in_ready", in_ready, 1);
`else
    send(WFI, 3'b000, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      chk("wfi_persist_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("wfi_persist_exit_in_ready", in_ready, 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ns_scoreboard_drained", ns_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
